rv32i_memaccess: RTL and testbench
==================================

// Module: rv32i_memaccess
// PURPOSE
//  Load/store unit for the MEMORYACCESS stage, directly downstream of EXECUTE in the unpipelined
//  5-stage FSM core. Takes the ALU result as byte address plus rs2 and funct3. Runs one Wishbone-
//  classic data-bus transaction, aligns store bytes and lane selects, and sign/zero-extends load data.
//  Stalls the stage FSM until the access completes, errors, or times out.
// PARAMETERS
//  TIMEOUT    255  max cycles waiting for ack before abort (>=2)
//  CNT_WIDTH  8    width of timeout counter (2**CNT_WIDTH > TIMEOUT)
// PORTS
//  clk                 in   1   clock
//  rst_n               in   1   reset, asynchronous, active-low
//  memoryaccess_stage  in   1   FSM is in MEMORYACCESS
//  opcode_load         in   1   instruction is a load
//  opcode_store        in   1   instruction is a store
//  funct3              in   3   access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  y                   in   32  ALU result = byte address
//  rs2                 in   32  store source value
//  stall_o             out  1   hold FSM in MEMORYACCESS while high
//  load_data_o         out  32  extended load result, valid from DONE until next access
//  misaligned_o        out  1   1-cycle pulse: misaligned H/W access, no bus cycle issued
//  bus_err_o           out  1   1-cycle pulse: timeout abort
//  wb_cyc_o, wb_stb_o  out  1   bus cycle/strobe
//  wb_we_o             out  1   1 = write
//  wb_adr_o            out  32  word address {y[31:2],2'b00}
//  wb_dat_o            out  32  lane-aligned store data
//  wb_sel_o            out  4   byte lane enables
//  wb_ack_i            in   1   bus acknowledge
//  wb_dat_i            in   32  bus read data
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (load_data_o=0, wb_* strobes 0, counter 0). Async reset mid-
//    transaction drops cyc/stb immediately; no completion or error pulse follows.
//  - access = memoryaccess_stage & (opcode_load|opcode_store); store wins if both set.
//  - misaligned: H with y[0]=1, W with y[1:0]!=0. Then misaligned_o pulses, stall_o=0, state stays
//    IDLE, no bus cycle.
//  - FSM states IDLE -> REQ -> DONE -> IDLE:
//    IDLE: aligned access -> latch addr/we/sel/data/funct3 into regs, go REQ.
//    REQ : cyc=stb=1, outputs from latched regs, held stable. ack -> latch extended read data
//          (loads only) into load_data_o, go DONE. Counter increments each REQ cycle; at
//          count==TIMEOUT-1 with no ack -> bus_err_o pulse, go DONE, load_data_o unchanged.
//    DONE: cyc=stb=0, stall_o=0 (FSM advances); go IDLE next edge.
//  - stall_o = access & ~misaligned & (state!=DONE); combinational. Min access 3 cycles (ack in first
//    REQ cycle) = 2 stall cycles.
//  - ack outside REQ is ignored. If memoryaccess_stage drops in REQ, the transaction still completes.
//  - Store align: SB sel=4'b0001<<y[1:0], dat={4{rs2[7:0]}}; SH sel=y[1]?4'b1100:4'b0011,
//    dat={2{rs2[15:0]}}; SW sel=4'b1111, dat=rs2. Load: sel=4'b1111.
//  - Load extend: byte = wb_dat_i>>(8*y[1:0]), half = wb_dat_i>>(16*y[1]). LB/LH sign-extend;
//    LBU/LHU zero-extend; LW pass-through. Undefined funct3 is treated as LW.
//  - Integration: the stage FSM gains a stall input; when it is high, stage_d=stage_q in MEMORYACCESS.
// STRUCTURE
//  - Shared package/header: funct3 load/store codes, state encodings (IDLE/REQ/DONE).
//  - One combinational sub-module rv32i_lsu_align handles store sel/data and load extension. Top
//    level holds the FSM, timeout counter, and output registers.
// TESTING
//  1. SB, y=0x103, rs2=0x000000AB, ack 1st REQ cycle -> sel=4'b1000, dat=0xABABABAB, adr=0x100,
//     we=1, stall_o high exactly 2 cycles.
//  2. LB y=0x102, dat_i=0x80FF7F00 -> load_data_o=0xFFFFFFFF; LBU same -> 0x000000FF;
//     LH y=0x102 -> 0xFFFF80FF.
//  3. LH y=0x101 -> misaligned_o 1 cycle, wb_cyc_o never high, stall_o=0; same for LW y=0x102.
//  4. LW y=0x200, ack 3 cycles after stb -> stall_o high 4 cycles, load_data_o=dat_i at DONE.
//  5. TIMEOUT=8, no ack -> cyc high 8 cycles, bus_err_o 1-cycle pulse, stall_o drops, cyc=0.
//  6. rst_n low in 2nd REQ cycle -> cyc/stb/stall_o 0 at once; after release a new SW completes.

Source files
------------

// File: rtl/rv32i_memaccess_pkg.sv
// Shared definitions for the MEMORYACCESS load/store unit.
// Holds the funct3 size/sign codes, the FSM state encoding and the access-size decode.
package rv32i_memaccess_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Undefined funct3 codes fall through to word size.
    function automatic lsu_size_e size_of(input logic [2:0] f3);
        lsu_size_e sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/rv32i_lsu_align.sv
// Combinational lane steering: store byte-lane selects/data replication and
// load byte/half extraction with sign or zero extension.
module rv32i_lsu_align
    import rv32i_memaccess_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_sel_o,
    output logic [31:0] st_dat_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_raw_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    // Store path: pick lanes from the low address bits, replicate data across all lanes.
    always_comb begin
        st_sel_o = 4'b1111;
        st_dat_o = st_data_i;
        case (size_of(st_funct3_i))
            SZ_B: begin
                st_sel_o = 4'b0001 << st_off_i;
                st_dat_o = {4{st_data_i[7:0]}};
            end
            SZ_H: begin
                st_sel_o = st_off_i[1] ? 4'b1100 : 4'b0011;
                st_dat_o = {2{st_data_i[15:0]}};
            end
            default: begin
                st_sel_o = 4'b1111;
                st_dat_o = st_data_i;
            end
        endcase
    end

    // Load path: shift the addressed byte/half down to bit 0, then extend.
    always_comb begin
        byte_shift = ld_raw_i >> {ld_off_i, 3'b000};
        half_shift = ld_raw_i >> {ld_off_i[1], 4'b0000};
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{byte_shift[7]}}, byte_shift[7:0]};
            F3_BU:   ld_data_o = {24'd0, byte_shift[7:0]};
            F3_H:    ld_data_o = {{16{half_shift[15]}}, half_shift[15:0]};
            F3_HU:   ld_data_o = {16'd0, half_shift[15:0]};
            default: ld_data_o = ld_raw_i;
        endcase
    end

endmodule

// File: rtl/rv32i_memaccess.sv
// MEMORYACCESS-stage load/store unit: one Wishbone-classic transaction per
// access, with stall generation, misalignment rejection and ack timeout.
module rv32i_memaccess
    import rv32i_memaccess_pkg::*;
#(
    parameter int TIMEOUT   = 255,
    parameter int CNT_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memoryaccess_stage,
    input  logic        opcode_load,
    input  logic        opcode_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] y,
    input  logic [31:0] rs2,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i
);

    lsu_state_e           state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 cyc_q;
    logic                 we_q;
    logic [31:0]          adr_q;
    logic [31:0]          dat_q;
    logic [3:0]           sel_q;
    logic [2:0]           funct3_q;
    logic [1:0]           off_q;
    logic [31:0]          load_data_q;
    logic                 bus_err_q;

    logic                 access;
    logic                 misaligned;
    lsu_size_e            size;
    logic [3:0]           st_sel;
    logic [31:0]          st_dat;
    logic [31:0]          ld_ext;

    rv32i_lsu_align u_align (
        .st_funct3_i (funct3),
        .st_off_i    (y[1:0]),
        .st_data_i   (rs2),
        .st_sel_o    (st_sel),
        .st_dat_o    (st_dat),
        .ld_funct3_i (funct3_q),
        .ld_off_i    (off_q),
        .ld_raw_i    (wb_dat_i),
        .ld_data_o   (ld_ext)
    );

    // Request decode; stall and misalignment are held low while in reset so the
    // stage FSM sees a quiet unit the instant reset asserts.
    always_comb begin
        access       = memoryaccess_stage & (opcode_load | opcode_store);
        size         = size_of(funct3);
        misaligned   = ((size == SZ_H) & y[0]) | ((size == SZ_W) & (|y[1:0]));
        stall_o      = rst_n & access & ~misaligned & (state_q != ST_DONE);
        misaligned_o = rst_n & access & misaligned & (state_q == ST_IDLE);
    end

    // Transaction FSM, timeout counter and registered bus/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            load_data_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (access && !misaligned) begin
                        adr_q    <= {y[31:2], 2'b00};
                        we_q     <= opcode_store;
                        sel_q    <= opcode_store ? st_sel : 4'b1111;
                        dat_q    <= opcode_store ? st_dat : 32'd0;
                        funct3_q <= funct3;
                        off_q    <= y[1:0];
                        cnt_q    <= '0;
                        cyc_q    <= 1'b1;
                        state_q  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (wb_ack_i) begin
                        if (!we_q) begin
                            load_data_q <= ld_ext;
                        end
                        cyc_q   <= 1'b0;
                        state_q <= ST_DONE;
                    end else if (cnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
                        bus_err_q <= 1'b1;
                        cyc_q     <= 1'b0;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    cyc_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = sel_q;
    assign load_data_o = load_data_q;
    assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_rv32i_memaccess.sv
// Self-checking bench for rv32i_memaccess: directed scenarios followed by
// random accesses compared against an arithmetic reference model.
module tb_rv32i_memaccess;

    localparam int TMO = 8;

    logic        clk;
    logic        rst_n;
    logic        memoryaccess_stage;
    logic        opcode_load;
    logic        opcode_store;
    logic [2:0]  funct3;
    logic [31:0] y;
    logic [31:0] rs2;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        misaligned_o;
    logic        bus_err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;

    int          checks;
    int          errors;
    logic [31:0] exp_ld;

    rv32i_memaccess #(.TIMEOUT(TMO), .CNT_WIDTH(8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .memoryaccess_stage (memoryaccess_stage),
        .opcode_load        (opcode_load),
        .opcode_store       (opcode_store),
        .funct3             (funct3),
        .y                  (y),
        .rs2                (rs2),
        .stall_o            (stall_o),
        .load_data_o        (load_data_o),
        .misaligned_o       (misaligned_o),
        .bus_err_o          (bus_err_o),
        .wb_cyc_o           (wb_cyc_o),
        .wb_stb_o           (wb_stb_o),
        .wb_we_o            (wb_we_o),
        .wb_adr_o           (wb_adr_o),
        .wb_dat_o           (wb_dat_o),
        .wb_sel_o           (wb_sel_o),
        .wb_ack_i           (wb_ack_i),
        .wb_dat_i           (wb_dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Access width in bytes, from the instruction's funct3.
    function automatic int size_bytes(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    // Expected load result from the raw bus word.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] raw);
        int unsigned b;
        int unsigned h;
        b = (raw >> (8 * (addr % 4))) & 32'hFF;
        h = (raw >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? 32'(int'(b) - 256) : 32'(b);
            3'b100:  return 32'(b);
            3'b001:  return (h >= 32768) ? 32'(int'(h) - 65536) : 32'(h);
            3'b101:  return 32'(h);
            default: return raw;
        endcase
    endfunction

    // One MEMORYACCESS visit. ack_at = REQ cycle (1-based) in which ack is
    // returned, 0 = never. stray = drive ack high whenever no cycle is open.
    task automatic run_access(input string name, input bit st, input bit ld,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int ack_at, input bit stray);
        int          n_stall, n_cyc, n_mis, n_err, nbytes, off;
        bit          done, is_st, mis, tmo, cyc_at_end;
        logic [3:0]  e_sel;
        logic [31:0] e_dat;
        n_stall = 0; n_cyc = 0; n_mis = 0; n_err = 0; done = 0; cyc_at_end = 0;
        is_st  = st;
        nbytes = size_bytes(f3);
        off    = int'(addr % 4);
        mis    = (off % nbytes) != 0;
        tmo    = (ack_at == 0) || (ack_at > TMO);
        if (is_st) begin
            e_sel = 4'(((1 << nbytes) - 1) << off);
            if (nbytes == 1)      e_dat = 32'(wdata[7:0]) * 32'h01010101;
            else if (nbytes == 2) e_dat = 32'(wdata[15:0]) * 32'h00010001;
            else                  e_dat = wdata;
        end else begin
            e_sel = 4'hF;
            e_dat = 32'd0;
        end
        memoryaccess_stage = 1'b1; opcode_load = ld; opcode_store = st;
        funct3 = f3; y = addr; rs2 = wdata; wb_dat_i = rdata;
        for (int c = 0; c < 40; c++) begin
            wb_ack_i = wb_cyc_o ? (n_cyc + 1 == ack_at) : stray;
            @(negedge clk);
            if (wb_cyc_o) begin
                n_cyc++;
                if (n_cyc == 1) begin
                    check({name, ".adr"}, wb_adr_o, addr & 32'hFFFF_FFFC);
                    check({name, ".we"}, 32'(wb_we_o), 32'(is_st));
                    check({name, ".sel"}, 32'(wb_sel_o), 32'(e_sel));
                    if (is_st) check({name, ".dat"}, wb_dat_o, e_dat);
                end
                check({name, ".stb"}, 32'(wb_stb_o), 32'd1);
            end
            if (stall_o) n_stall++;
            if (misaligned_o) n_mis++;
            if (bus_err_o) n_err++;
            if (!stall_o) begin
                done = 1;
                cyc_at_end = wb_cyc_o;
                break;
            end
            @(posedge clk); #1;
        end
        check({name, ".bounded"}, 32'(done), 32'd1);
        if (mis) begin
            check({name, ".mis"}, n_mis, 1);
            check({name, ".cyc_cnt"}, n_cyc, 0);
            check({name, ".stall_cnt"}, n_stall, 0);
        end else begin
            check({name, ".mis"}, n_mis, 0);
            check({name, ".cyc_cnt"}, n_cyc, tmo ? TMO : ack_at);
            check({name, ".stall_cnt"}, n_stall, (tmo ? TMO : ack_at) + 1);
            check({name, ".err"}, n_err, tmo ? 1 : 0);
            check({name, ".cyc_end"}, 32'(cyc_at_end), 32'd0);
            if (!is_st && !tmo) exp_ld = model_load(f3, addr, rdata);
        end
        check({name, ".load_data"}, load_data_o, exp_ld);
        @(posedge clk); #1;
        memoryaccess_stage = 1'b0; opcode_load = 1'b0; opcode_store = 1'b0; wb_ack_i = 1'b0;
        $display("txn %-10s st=%0d ld=%0d f3=%03b y=%08h ack_at=%0d cyc=%0d stall=%0d mis=%0d err=%0d ld_out=%08h",
                 name, st, ld, f3, addr, ack_at, n_cyc, n_stall, n_mis, n_err, load_data_o);
    endtask

    initial begin
        checks = 0; errors = 0; exp_ld = 32'd0;
        rst_n = 1'b0; memoryaccess_stage = 1'b0; opcode_load = 1'b0; opcode_store = 1'b0;
        funct3 = 3'b000; y = 32'd0; rs2 = 32'd0; wb_ack_i = 1'b0; wb_dat_i = 32'd0;
        repeat (3) @(negedge clk);
        check("rst.cyc", 32'(wb_cyc_o), 32'd0);
        check("rst.stb", 32'(wb_stb_o), 32'd0);
        check("rst.stall", 32'(stall_o), 32'd0);
        check("rst.load_data", load_data_o, 32'd0);
        check("rst.err", 32'(bus_err_o), 32'd0);
        check("rst.sel", 32'(wb_sel_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed scenarios
        run_access("sb103", 1, 0, 3'b000, 32'h103, 32'h0000_00AB, 32'h0, 1, 0);
        run_access("lb102", 0, 1, 3'b000, 32'h102, 32'h0, 32'h80FF_7F00, 1, 0);
        run_access("lbu102", 0, 1, 3'b100, 32'h102, 32'h0, 32'h80FF_7F00, 1, 0);
        run_access("lh102", 0, 1, 3'b001, 32'h102, 32'h0, 32'h80FF_7F00, 2, 1);
        run_access("lh101", 0, 1, 3'b001, 32'h101, 32'h0, 32'h0, 1, 0);
        run_access("lw102", 0, 1, 3'b010, 32'h102, 32'h0, 32'h0, 1, 0);
        run_access("lw200", 0, 1, 3'b010, 32'h200, 32'h0, 32'hDEAD_BEEF, 3, 1);
        run_access("timeout", 0, 1, 3'b010, 32'h204, 32'h0, 32'h1234_5678, 0, 0);
        run_access("ack_last", 1, 1, 3'b001, 32'h20A, 32'h0000_BEEF, 32'h0, TMO, 0);

        // Reset asserted in the second REQ cycle of a store
        memoryaccess_stage = 1'b1; opcode_store = 1'b1; funct3 = 3'b010;
        y = 32'h300; rs2 = 32'hCAFE_F00D; wb_ack_i = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        check("midrst.cyc_before", 32'(wb_cyc_o), 32'd1);
        rst_n = 1'b0; #1;
        check("midrst.cyc", 32'(wb_cyc_o), 32'd0);
        check("midrst.stb", 32'(wb_stb_o), 32'd0);
        check("midrst.stall", 32'(stall_o), 32'd0);
        exp_ld = 32'd0;
        check("midrst.load_data", load_data_o, exp_ld);
        @(negedge clk);
        check("midrst.err", 32'(bus_err_o), 32'd0);
        memoryaccess_stage = 1'b0; opcode_store = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_access("sw_after", 1, 0, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0, 2, 0);

        // Random accesses
        for (int i = 0; i < 60; i++) begin
            int          kind;
            logic [2:0]  f3r;
            kind = $urandom_range(0, 2);
            f3r  = 3'($urandom_range(0, 7));
            run_access("rand", kind != 0, kind != 1, f3r, $urandom, $urandom, $urandom,
                       $urandom_range(0, TMO + 2), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
